// File: rtl/wb_arbiter_2m_if.sv
// Bus bundle for the two-master Wishbone arbiter: both master ports, the shared slave port and the grant.
// The "slave" modport is the arbiter's view; "master" is the view of the surrounding masters/slave.
interface wb_arbiter_2m_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] m0_adr_i;
    logic [DATA_WIDTH-1:0] m0_dat_i;
    logic [DATA_WIDTH-1:0] m0_dat_o;
    logic                  m0_we_i;
    logic [SEL_WIDTH-1:0]  m0_sel_i;
    logic                  m0_stb_i;
    logic                  m0_cyc_i;
    logic                  m0_ack_o;

    logic [ADDR_WIDTH-1:0] m1_adr_i;
    logic [DATA_WIDTH-1:0] m1_dat_i;
    logic [DATA_WIDTH-1:0] m1_dat_o;
    logic                  m1_we_i;
    logic [SEL_WIDTH-1:0]  m1_sel_i;
    logic                  m1_stb_i;
    logic                  m1_cyc_i;
    logic                  m1_ack_o;

    logic [ADDR_WIDTH-1:0] s_adr_o;
    logic [DATA_WIDTH-1:0] s_dat_o;
    logic [DATA_WIDTH-1:0] s_dat_i;
    logic                  s_we_o;
    logic [SEL_WIDTH-1:0]  s_sel_o;
    logic                  s_stb_o;
    logic                  s_cyc_o;
    logic                  s_ack_i;

    logic [1:0]            grant_o;

    modport slave (
        input  m0_adr_i, m0_dat_i, m0_we_i, m0_sel_i, m0_stb_i, m0_cyc_i,
        output m0_dat_o, m0_ack_o,
        input  m1_adr_i, m1_dat_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i,
        output m1_dat_o, m1_ack_o,
        output s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
        input  s_dat_i, s_ack_i,
        output grant_o
    );

    modport master (
        output m0_adr_i, m0_dat_i, m0_we_i, m0_sel_i, m0_stb_i, m0_cyc_i,
        input  m0_dat_o, m0_ack_o,
        output m1_adr_i, m1_dat_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i,
        input  m1_dat_o, m1_ack_o,
        input  s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
        output s_dat_i, s_ack_i,
        input  grant_o
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone B4 classic arbiter: round-robin grant locked for a whole bus cycle,
// registered grant state with combinational request/response muxing.
module wb_arbiter_2m #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    wb_arbiter_2m_if.slave bus,
    output logic [1:0] fsm_state
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   last_grant_q;
    logic   last_grant_d;

    logic req0;
    logic req1;

    logic [ADDR_WIDTH-1:0] adr_mux;
    logic [DATA_WIDTH-1:0] dat_mux;
    logic                  we_mux;
    logic [SEL_WIDTH-1:0]  sel_mux;
    logic                  stb_mux;
    logic                  cyc_mux;
    logic                  ack0;
    logic                  ack1;
    logic [1:0]            grant;

    // Handshake: a transfer is offered while cyc&stb are high and completes on the cycle ack is high;
    // ack is only ever routed back to the owning master while that master still holds cyc and stb.
    assign req0 = bus.m0_cyc_i & bus.m0_stb_i;
    assign req1 = bus.m1_cyc_i & bus.m1_stb_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // An owner is only ever released through IDLE, so the bus always sees one dead cycle between owners.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    if (last_grant_q) begin
                        state_d      = GRANT0;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d      = GRANT1;
                        last_grant_d = 1'b1;
                    end
                end else if (req0) begin
                    state_d      = GRANT0;
                    last_grant_d = 1'b0;
                end else if (req1) begin
                    state_d      = GRANT1;
                    last_grant_d = 1'b1;
                end
            end
            GRANT0: begin
                if (!bus.m0_cyc_i) state_d = IDLE;
            end
            GRANT1: begin
                if (!bus.m1_cyc_i) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        adr_mux = '0;
        dat_mux = '0;
        we_mux  = 1'b0;
        sel_mux = '0;
        stb_mux = 1'b0;
        cyc_mux = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        grant   = 2'b00;
        case (state_q)
            GRANT0: begin
                adr_mux = bus.m0_adr_i;
                dat_mux = bus.m0_dat_i;
                we_mux  = bus.m0_we_i;
                sel_mux = bus.m0_sel_i;
                stb_mux = bus.m0_stb_i;
                cyc_mux = bus.m0_cyc_i;
                ack0    = bus.s_ack_i & bus.m0_cyc_i & bus.m0_stb_i;
                grant   = 2'b01;
            end
            GRANT1: begin
                adr_mux = bus.m1_adr_i;
                dat_mux = bus.m1_dat_i;
                we_mux  = bus.m1_we_i;
                sel_mux = bus.m1_sel_i;
                stb_mux = bus.m1_stb_i;
                cyc_mux = bus.m1_cyc_i;
                ack1    = bus.s_ack_i & bus.m1_cyc_i & bus.m1_stb_i;
                grant   = 2'b10;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

    assign bus.s_adr_o  = adr_mux;
    assign bus.s_dat_o  = dat_mux;
    assign bus.s_we_o   = we_mux;
    assign bus.s_sel_o  = sel_mux;
    assign bus.s_stb_o  = stb_mux;
    assign bus.s_cyc_o  = cyc_mux;
    assign bus.m0_ack_o = ack0;
    assign bus.m1_ack_o = ack1;
    assign bus.grant_o  = grant;

    // Read data is broadcast; each master qualifies it with its own ack.
    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;

    assign fsm_state = state_q;
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: hand-driven masters and slave, expected values written inline.
module tb_wb_arbiter_2m;
  logic       clk;
  logic       rst;
  logic [1:0] fsm_state;
  int         n_checks;
  int         n_fail;
  logic [31:0] mem [logic [31:0]];

  wb_arbiter_2m_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  wb_arbiter_2m #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.m0_cyc_i = cyc;
    bus.m0_stb_i = stb;
    bus.m0_we_i  = we;
    bus.m0_adr_i = adr;
    bus.m0_dat_i = dat;
    bus.m0_sel_i = sel;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.m1_cyc_i = cyc;
    bus.m1_stb_i = stb;
    bus.m1_we_i  = we;
    bus.m1_adr_i = adr;
    bus.m1_dat_i = dat;
    bus.m1_sel_i = sel;
  endtask

  task automatic do_reset();
    set_m0(0, 0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0, 0);
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = '0;
    rst = 1'b1;
    next();
    rst = 1'b0;
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;

    // reset state
    do_reset();
    #1;
    check("rst_grant", bus.grant_o, 2'b00);
    check("rst_state", fsm_state, 2'd0);
    check("rst_cyc", bus.s_cyc_o, 1'b0);
    check("rst_stb", bus.s_stb_o, 1'b0);
    check("rst_we", bus.s_we_o, 1'b0);
    check("rst_sel", bus.s_sel_o, 4'h0);
    check("rst_adr", bus.s_adr_o, 32'h0);
    check("rst_dat", bus.s_dat_o, 32'h0);
    check("rst_ack0", bus.m0_ack_o, 1'b0);
    check("rst_ack1", bus.m1_ack_o, 1'b0);

    // m0 single read, ack three cycles after stb
    set_m0(1, 1, 0, 32'h10, 32'h0, 4'hF);
    #1;
    check("t1_idle_grant", bus.grant_o, 2'b00);
    check("t1_idle_cyc", bus.s_cyc_o, 1'b0);
    next(); #1;
    check("t1_grant", bus.grant_o, 2'b01);
    check("t1_cyc", bus.s_cyc_o, 1'b1);
    check("t1_stb", bus.s_stb_o, 1'b1);
    check("t1_adr", bus.s_adr_o, 32'h10);
    check("t1_we", bus.s_we_o, 1'b0);
    for (int k = 0; k < 2; k++) begin
      next(); #1;
      check("t1_wait_ack0", bus.m0_ack_o, 1'b0);
    end
    next();
    bus.s_dat_i = 32'hDEAD_BEEF;
    bus.s_ack_i = 1'b1;
    #1;
    check("t1_ack0", bus.m0_ack_o, 1'b1);
    check("t1_dat0", bus.m0_dat_o, 32'hDEAD_BEEF);
    check("t1_ack1", bus.m1_ack_o, 1'b0);
    next();
    set_m0(0, 0, 0, 0, 0, 0);
    bus.s_ack_i = 1'b0;
    #1;
    check("t1_rel_cyc", bus.s_cyc_o, 1'b0);
    check("t1_rel_grant", bus.grant_o, 2'b01);
    next(); #1;
    check("t1_idle_after", bus.grant_o, 2'b00);

    // simultaneous request after reset: m0 first, then m1, then m0 again
    do_reset();
    set_m0(1, 1, 0, 32'h20, 32'h0, 4'hF);
    set_m1(1, 1, 0, 32'h24, 32'h0, 4'hF);
    #1;
    check("t2_idle", bus.grant_o, 2'b00);
    next(); #1;
    check("t2_grant0", bus.grant_o, 2'b01);
    check("t2_adr0", bus.s_adr_o, 32'h20);
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'h1234;
    #1;
    check("t2_ack0", bus.m0_ack_o, 1'b1);
    check("t2_noack1", bus.m1_ack_o, 1'b0);
    next();
    set_m0(0, 0, 0, 0, 0, 0);
    bus.s_ack_i = 1'b0;
    #1;
    check("t2_drop_grant", bus.grant_o, 2'b01);
    check("t2_drop_cyc", bus.s_cyc_o, 1'b0);
    next(); #1;
    check("t2_gap", bus.grant_o, 2'b00);
    next(); #1;
    check("t2_grant1", bus.grant_o, 2'b10);
    check("t2_adr1", bus.s_adr_o, 32'h24);
    set_m0(1, 1, 0, 32'h28, 32'h0, 4'hF);
    bus.s_ack_i = 1'b1;
    #1;
    check("t2_ack1", bus.m1_ack_o, 1'b1);
    check("t2_noack0", bus.m0_ack_o, 1'b0);
    next();
    set_m1(0, 0, 0, 0, 0, 0);
    bus.s_ack_i = 1'b0;
    #1;
    check("t2_hold1", bus.grant_o, 2'b10);
    next(); #1;
    check("t2_gap2", bus.grant_o, 2'b00);
    next(); #1;
    check("t2_regrant0", bus.grant_o, 2'b01);
    check("t2_adr0b", bus.s_adr_o, 32'h28);
    bus.s_ack_i = 1'b1;
    #1;
    check("t2_ack0b", bus.m0_ack_o, 1'b1);
    next();
    set_m0(0, 0, 0, 0, 0, 0);
    bus.s_ack_i = 1'b0;
    next(); #1;
    check("t2_end_idle", bus.grant_o, 2'b00);

    // back-to-back single writes from both masters: strict alternation
    do_reset();
    set_m0(1, 1, 1, 32'h80, 32'hA0, 4'hF);
    set_m1(1, 1, 1, 32'h100, 32'h11, 4'b0011);
    next();
    for (int i = 0; i < 4; i++) begin
      bus.s_ack_i = 1'b1;
      #1;
      check("t3_grant0", bus.grant_o, 2'b01);
      check("t3_adr0", bus.s_adr_o, 32'h80 + 32'(4 * i));
      check("t3_dat0", bus.s_dat_o, 32'hA0 + 32'(i));
      check("t3_we0", bus.s_we_o, 1'b1);
      check("t3_ack0", bus.m0_ack_o, 1'b1);
      check("t3_noack1", bus.m1_ack_o, 1'b0);
      next();
      set_m0(0, 0, 0, 0, 0, 0);
      bus.s_ack_i = 1'b0;
      #1;
      check("t3_rel0_cyc", bus.s_cyc_o, 1'b0);
      next();
      if (i < 3) set_m0(1, 1, 1, 32'h80 + 32'(4 * (i + 1)), 32'hA0 + 32'(i + 1), 4'hF);
      #1;
      check("t3_gap0", bus.grant_o, 2'b00);
      next();
      bus.s_ack_i = 1'b1;
      #1;
      check("t3_grant1", bus.grant_o, 2'b10);
      check("t3_sel1", bus.s_sel_o, 4'b0011);
      check("t3_adr1", bus.s_adr_o, 32'h100);
      check("t3_dat1", bus.s_dat_o, 32'h11 * 32'(i + 1));
      check("t3_ack1", bus.m1_ack_o, 1'b1);
      check("t3_noack0", bus.m0_ack_o, 1'b0);
      next();
      set_m1(0, 0, 0, 0, 0, 0);
      bus.s_ack_i = 1'b0;
      #1;
      check("t3_rel1_grant", bus.grant_o, 2'b10);
      check("t3_rel1_stb", bus.s_stb_o, 1'b0);
      next();
      if (i < 3) set_m1(1, 1, 1, 32'h100, 32'h11 * 32'(i + 2), 4'b0011);
      #1;
      check("t3_gap1", bus.grant_o, 2'b00);
      next();
    end
    #1;
    check("t3_end_idle", bus.grant_o, 2'b00);

    // m1 locked bus cycle: write then read back, m0 waiting throughout
    set_m1(1, 1, 1, 32'h200, 32'hCAFE_F00D, 4'hF);
    next();
    set_m0(1, 1, 0, 32'h40, 32'h0, 4'hF);
    #1;
    check("t4_grant1", bus.grant_o, 2'b10);
    bus.s_ack_i = 1'b1;
    if (bus.s_we_o) mem[bus.s_adr_o] = bus.s_dat_o;
    #1;
    check("t4_wack1", bus.m1_ack_o, 1'b1);
    check("t4_noack0", bus.m0_ack_o, 1'b0);
    next();
    bus.m1_stb_i = 1'b0;
    bus.s_ack_i  = 1'b0;
    #1;
    check("t4_lock_grant", bus.grant_o, 2'b10);
    check("t4_lock_cyc", bus.s_cyc_o, 1'b1);
    check("t4_lock_stb", bus.s_stb_o, 1'b0);
    next();
    bus.m1_stb_i = 1'b1;
    bus.m1_we_i  = 1'b0;
    #1;
    bus.s_dat_i = mem.exists(bus.s_adr_o) ? mem[bus.s_adr_o] : 32'h0;
    bus.s_ack_i = 1'b1;
    #1;
    check("t4_rdat1", bus.m1_dat_o, 32'hCAFE_F00D);
    check("t4_rack1", bus.m1_ack_o, 1'b1);
    check("t4_noack0b", bus.m0_ack_o, 1'b0);
    check("t4_grant1b", bus.grant_o, 2'b10);
    next();
    set_m1(0, 0, 0, 0, 0, 0);
    bus.s_ack_i = 1'b0;
    #1;
    check("t4_rel_grant", bus.grant_o, 2'b10);
    next(); #1;
    check("t4_gap", bus.grant_o, 2'b00);
    next(); #1;
    check("t4_grant0", bus.grant_o, 2'b01);
    check("t4_adr0", bus.s_adr_o, 32'h40);
    bus.s_ack_i = 1'b1;
    #1;
    check("t4_ack0", bus.m0_ack_o, 1'b1);
    next();
    set_m0(0, 0, 0, 0, 0, 0);
    bus.s_ack_i = 1'b0;
    next();

    // m0 abandons its cycle; late slave ack must not leak to anyone
    set_m0(1, 1, 0, 32'h50, 32'h0, 4'hF);
    next(); #1;
    check("t5_grant0", bus.grant_o, 2'b01);
    check("t5_stb", bus.s_stb_o, 1'b1);
    set_m1(1, 1, 1, 32'h300, 32'h55, 4'hF);
    next();
    set_m0(0, 0, 0, 0, 0, 0);
    #1;
    check("t5_abort_cyc", bus.s_cyc_o, 1'b0);
    check("t5_abort_stb", bus.s_stb_o, 1'b0);
    check("t5_abort_grant", bus.grant_o, 2'b01);
    next();
    bus.s_ack_i = 1'b1;
    #1;
    check("t5_idle_grant", bus.grant_o, 2'b00);
    check("t5_late_ack0", bus.m0_ack_o, 1'b0);
    check("t5_late_ack1", bus.m1_ack_o, 1'b0);
    next();
    bus.s_ack_i = 1'b0;
    #1;
    check("t5_grant1", bus.grant_o, 2'b10);
    check("t5_adr1", bus.s_adr_o, 32'h300);

    // reset in the middle of the m1 write
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    bus.s_ack_i = 1'b1;
    set_m0(1, 1, 0, 32'h60, 32'h0, 4'hF);
    #1;
    check("t6_grant", bus.grant_o, 2'b00);
    check("t6_state", fsm_state, 2'd0);
    check("t6_cyc", bus.s_cyc_o, 1'b0);
    check("t6_stb", bus.s_stb_o, 1'b0);
    check("t6_we", bus.s_we_o, 1'b0);
    check("t6_sel", bus.s_sel_o, 4'h0);
    check("t6_adr", bus.s_adr_o, 32'h0);
    check("t6_dat", bus.s_dat_o, 32'h0);
    check("t6_ack0", bus.m0_ack_o, 1'b0);
    check("t6_ack1", bus.m1_ack_o, 1'b0);
    next();
    bus.s_ack_i = 1'b0;
    #1;
    check("t6_tie_grant0", bus.grant_o, 2'b01);
    check("t6_tie_adr", bus.s_adr_o, 32'h60);

    set_m0(0, 0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0, 0);
    next();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
